// File: rtl/mem_step_4_ctrl.sv
// mem_step_4_ctrl: memory-access stage (step 4) of the multi-cycle CPU.
// Issues data-memory reads/writes over a req/ack handshake, captures load
// data and hands the opcode to step 5 (which selects load_data for lw).
// Optional build macro MEM_STEP_4_SUBWORD_EN adds byte/half loads and stores
// (lb, lbu, lh, lhu, sb, sh) with per-lane byte enables and extraction.
//
// state | meaning
// IDLE  | waiting for start; decodes opcode and alignment
// WAIT  | dmem_req held high until ack or timeout
// DONE  | done pulse for one cycle, then back to IDLE
module mem_step_4_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [5:0]        opcode_step_4,
    input  logic [ADDR_W-1:0] alu_result,
    input  logic [31:0]       store_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic [31:0]       load_data,
    output logic [5:0]        opcode_step_5,
    output logic              done,
    output logic              err_misalign,
    output logic              err_timeout
);

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
`ifdef MEM_STEP_4_SUBWORD_EN
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
`endif

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [5:0]  op_q;
    logic [1:0]  ofs_q;
    logic [1:0]  size_q;
    logic        sx_q;

    logic        dec_mem;
    logic        dec_we;
    logic        dec_sx;
    logic        dec_mis;
    logic [1:0]  dec_size;
    logic [3:0]  dec_be;
    logic [31:0] dec_wdata;

    // Picks the addressed lane out of the read word and extends it.
    function automatic logic [31:0] lane_extract(input logic [31:0] d,
                                                 input logic [1:0]  ofs,
                                                 input logic [1:0]  sz,
                                                 input logic        sx);
        logic [7:0]  b;
        logic [15:0] h;
        case (ofs)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = ofs[1] ? d[31:16] : d[15:0];
        case (sz)
            SZ_BYTE: lane_extract = {{24{sx & b[7]}}, b};
            SZ_HALF: lane_extract = {{16{sx & h[15]}}, h};
            default: lane_extract = d;
        endcase
    endfunction

    // Opcode decode: memory-op class, access size, alignment, lanes.
    always_comb begin
        dec_mem  = 1'b0;
        dec_we   = 1'b0;
        dec_sx   = 1'b0;
        dec_size = SZ_WORD;
        case (opcode_step_4)
            OP_LW:  dec_mem = 1'b1;
            OP_SW:  begin dec_mem = 1'b1; dec_we = 1'b1; end
`ifdef MEM_STEP_4_SUBWORD_EN
            OP_LB:  begin dec_mem = 1'b1; dec_size = SZ_BYTE; dec_sx = 1'b1; end
            OP_LBU: begin dec_mem = 1'b1; dec_size = SZ_BYTE; end
            OP_LH:  begin dec_mem = 1'b1; dec_size = SZ_HALF; dec_sx = 1'b1; end
            OP_LHU: begin dec_mem = 1'b1; dec_size = SZ_HALF; end
            OP_SB:  begin dec_mem = 1'b1; dec_size = SZ_BYTE; dec_we = 1'b1; end
            OP_SH:  begin dec_mem = 1'b1; dec_size = SZ_HALF; dec_we = 1'b1; end
`endif
            default: ;
        endcase
        case (dec_size)
            SZ_BYTE: begin
                dec_mis   = 1'b0;
                dec_be    = 4'b0001 << alu_result[1:0];
                dec_wdata = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                dec_mis   = dec_mem & alu_result[0];
                dec_be    = alu_result[1] ? 4'b1100 : 4'b0011;
                dec_wdata = {2{store_data[15:0]}};
            end
            default: begin
                dec_mis   = dec_mem & (|alu_result[1:0]);
                dec_be    = 4'b1111;
                dec_wdata = store_data;
            end
        endcase
    end

    // Controller FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            op_q          <= '0;
            ofs_q         <= '0;
            size_q        <= SZ_WORD;
            sx_q          <= 1'b0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            dmem_be       <= '0;
            load_data     <= '0;
            opcode_step_5 <= '0;
            done          <= 1'b0;
            err_misalign  <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (dec_mem && !dec_mis) begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= dec_we;
                            dmem_addr  <= {alu_result[ADDR_W-1:2], 2'b00};
                            dmem_wdata <= dec_wdata;
                            dmem_be    <= dec_be;
                            op_q       <= opcode_step_4;
                            ofs_q      <= alu_result[1:0];
                            size_q     <= dec_size;
                            sx_q       <= dec_sx;
                            cnt_q      <= '0;
                            state_q    <= S_WAIT;
                        end else begin
                            if (dec_mem) begin
                                err_misalign <= 1'b1;
                                load_data    <= '0;
                            end
                            opcode_step_5 <= opcode_step_4;
                            done          <= 1'b1;
                            state_q       <= S_DONE;
                        end
                    end
                end
                S_WAIT: begin
                    if (dmem_ack) begin
                        if (!dmem_we) begin
                            load_data <= lane_extract(dmem_rdata, ofs_q, size_q, sx_q);
                        end
                        dmem_req      <= 1'b0;
                        cnt_q         <= '0;
                        opcode_step_5 <= op_q;
                        done          <= 1'b1;
                        state_q       <= S_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        err_timeout   <= 1'b1;
                        load_data     <= '0;
                        dmem_req      <= 1'b0;
                        cnt_q         <= '0;
                        opcode_step_5 <= op_q;
                        done          <= 1'b1;
                        state_q       <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_step_4_ctrl.sv
// Directed bench for mem_step_4_ctrl (default TIMEOUT_CYCLES = 16).
// Sub-word cases run only when MEM_STEP_4_SUBWORD_EN is defined.
module tb_mem_step_4_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  opcode_step_4;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] load_data;
    logic [5:0]  opcode_step_5;
    logic        done;
    logic        err_misalign;
    logic        err_timeout;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    mem_step_4_ctrl #(.TIMEOUT_CYCLES(16), .ADDR_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .opcode_step_4 (opcode_step_4),
        .alu_result    (alu_result),
        .store_data    (store_data),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_be       (dmem_be),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .load_data     (load_data),
        .opcode_step_5 (opcode_step_5),
        .done          (done),
        .err_misalign  (err_misalign),
        .err_timeout   (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sd);
        start         = 1'b1;
        opcode_step_4 = op;
        alu_result    = addr;
        store_data    = sd;
        tick();
        start         = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        opcode_step_4 = '0;
        alu_result    = '0;
        store_data    = '0;
        dmem_ack      = 1'b0;
        dmem_rdata    = '0;
        tick();
        tick();
        chk("rst_req",    32'(dmem_req), 32'd0);
        chk("rst_done",   32'(done), 32'd0);
        chk("rst_load",   load_data, 32'd0);
        chk("rst_op5",    32'(opcode_step_5), 32'd0);
        chk("rst_errmis", 32'(err_misalign), 32'd0);
        chk("rst_errto",  32'(err_timeout), 32'd0);
        rst = 1'b0;
        tick();

        // lw 0x10, ack on third WAIT cycle
        issue(6'b100011, 32'h0000_0010, 32'h0);
        chk("lw_req_c1",  32'(dmem_req), 32'd1);
        chk("lw_we",      32'(dmem_we), 32'd0);
        chk("lw_addr",    dmem_addr, 32'h0000_0010);
        chk("lw_be",      32'(dmem_be), 32'hF);
        tick();
        chk("lw_req_c2",  32'(dmem_req), 32'd1);
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        chk("lw_req_c3",  32'(dmem_req), 32'd1);
        chk("lw_nodone",  32'(done), 32'd0);
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        chk("lw_done",    32'(done), 32'd1);
        chk("lw_reqdrop", 32'(dmem_req), 32'd0);
        chk("lw_load",    load_data, 32'hDEAD_BEEF);
        chk("lw_op5",     32'(opcode_step_5), 32'h23);
        tick();
        chk("lw_done1cy", 32'(done), 32'd0);
        tick();

        // sw 0x20, ack on first WAIT cycle
        issue(6'b101011, 32'h0000_0020, 32'h1234_5678);
        chk("sw_req",     32'(dmem_req), 32'd1);
        chk("sw_we",      32'(dmem_we), 32'd1);
        chk("sw_wdata",   dmem_wdata, 32'h1234_5678);
        chk("sw_be",      32'(dmem_be), 32'hF);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h5555_AAAA;
        tick();
        dmem_ack   = 1'b0;
        chk("sw_done",    32'(done), 32'd1);
        chk("sw_load",    load_data, 32'hDEAD_BEEF);
        chk("sw_op5",     32'(opcode_step_5), 32'h2B);
        tick();
        tick();

        // non-memory opcode
        issue(6'b000000, 32'h0000_0013, 32'h0);
        chk("add_req",    32'(dmem_req), 32'd0);
        chk("add_done",   32'(done), 32'd1);
        chk("add_op5",    32'(opcode_step_5), 32'h00);
        chk("add_load",   load_data, 32'hDEAD_BEEF);
        chk("add_errmis", 32'(err_misalign), 32'd0);
        tick();
        tick();

        // misaligned lw, then a normal lw
        issue(6'b100011, 32'h0000_0013, 32'h0);
        chk("mis_req",    32'(dmem_req), 32'd0);
        chk("mis_done",   32'(done), 32'd1);
        chk("mis_err",    32'(err_misalign), 32'd1);
        chk("mis_load",   load_data, 32'h0);
        tick();
        issue(6'b100011, 32'h0000_0040, 32'h0);
        chk("post_req",   32'(dmem_req), 32'd1);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFE_0001;
        tick();
        dmem_ack   = 1'b0;
        chk("post_done",  32'(done), 32'd1);
        chk("post_load",  load_data, 32'hCAFE_0001);
        chk("post_errst", 32'(err_misalign), 32'd1);
        tick();
        tick();

        // ack on the same edge the timeout would fire: ack wins
        issue(6'b100011, 32'h0000_0044, 32'h0);
        for (int i = 1; i < 16; i++) tick();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h0BAD_F00D;
        chk("edge_req",   32'(dmem_req), 32'd1);
        tick();
        dmem_ack   = 1'b0;
        chk("edge_done",  32'(done), 32'd1);
        chk("edge_noto",  32'(err_timeout), 32'd0);
        chk("edge_load",  load_data, 32'h0BAD_F00D);
        tick();
        tick();

        // no ack at all: timeout after 16 WAIT cycles
        issue(6'b100011, 32'h0000_0048, 32'h0);
        begin
            int req_cycles = 0;
            for (int i = 0; i < 16; i++) begin
                if (dmem_req === 1'b1) req_cycles++;
                tick();
            end
            chk("to_reqcyc", 32'(req_cycles), 32'd16);
        end
        chk("to_reqdrop", 32'(dmem_req), 32'd0);
        chk("to_done",    32'(done), 32'd1);
        chk("to_err",     32'(err_timeout), 32'd1);
        chk("to_load",    load_data, 32'h0);
        tick();
        tick();

`ifdef MEM_STEP_4_SUBWORD_EN
        // lb at byte 3, sign-extended
        issue(6'b100000, 32'h0000_0003, 32'h0);
        chk("lb_be",      32'(dmem_be), 32'h8);
        chk("lb_addr",    dmem_addr, 32'h0000_0000);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h80FF_FF7F;
        tick();
        dmem_ack   = 1'b0;
        chk("lb_load",    load_data, 32'hFFFF_FF80);
        tick();
        tick();
        // lhu at half 1, zero-extended
        issue(6'b100101, 32'h0000_0002, 32'h0);
        chk("lhu_be",     32'(dmem_be), 32'hC);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h80FF_FF7F;
        tick();
        dmem_ack   = 1'b0;
        chk("lhu_load",   load_data, 32'h0000_80FF);
        tick();
        tick();
`endif

        // reset in the middle of WAIT drops the request immediately
        issue(6'b100011, 32'h0000_0050, 32'h0);
        tick();
        chk("mid_req",    32'(dmem_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rstreq", 32'(dmem_req), 32'd0);
        chk("mid_rstto",  32'(err_timeout), 32'd0);
        chk("mid_rstmis", 32'(err_misalign), 32'd0);
        chk("mid_rstld",  load_data, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        issue(6'b000000, 32'h0, 32'h0);
        chk("rec_done",   32'(done), 32'd1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_step_4_ctrl.md
Name: mem_step_4_ctrl

Overview:
- Memory-access stage controller (step 4) of the multi-cycle CPU.
- Issues data-memory read/write transactions over a req/ack handshake and captures load data.
- Hands the opcode to step 5. Step 5 selects load_data for write-back when opcode_step_5 = lw (6'b100011).
- It is the producer end of the write-back data path.

Parameters:
- TIMEOUT_CYCLES, 16, max WAIT cycles without dmem_ack before abort; legal range 1..255.
- ADDR_W, 32, width of dmem_addr / alu_result.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse: step-4 operands valid.
- opcode_step_4  input  6  instruction opcode.
- alu_result  input  ADDR_W  effective address.
- store_data  input  32  rt value for stores.
- dmem_req  output  1  memory request, held until ack.
- dmem_we  output  1  1 = write (sw), 0 = read.
- dmem_addr  output  ADDR_W  word-aligned address.
- dmem_wdata  output  32  write data.
- dmem_be  output  4  byte enables.
- dmem_ack  input  1  memory completes the transaction this cycle.
- dmem_rdata  input  32  read data, valid with dmem_ack.
- load_data  output  32  registered load result for step 5.
- opcode_step_5  output  6  registered opcode for step 5.
- done  output  1  one-cycle pulse: step 4 complete.
- err_misalign  output  1  sticky: misaligned access.
- err_timeout  output  1  sticky: no ack within TIMEOUT_CYCLES.

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0, including load_data, opcode_step_5 and both error flags.
  - Wait counter 0.
- Reset mid-operation clears state and drops dmem_req asynchronously. The transaction is abandoned.
- States: IDLE, WAIT, DONE.
- IDLE:
  - start is sampled only in IDLE and ignored in all other states.
  - Memory ops are lw (100011) and sw (101011). Any other opcode is a non-memory op.
  - Memory op with alu_result[1:0] == 0: latch dmem_addr, dmem_wdata, dmem_we (sw → 1), dmem_be = 4'b1111 and opcode → WAIT.
  - Memory op with alu_result[1:0] != 0: set err_misalign, no request, load_data ← 0 → DONE.
  - Non-memory opcode: no request, load_data unchanged → DONE.
- WAIT:
  - dmem_req = 1.
  - dmem_ack = 1 at an edge:
    - for lw, load_data ← dmem_rdata;
    - for sw, load_data is unchanged;
    - counter cleared → DONE.
  - An ack is accepted on the first WAIT cycle, so minimum memory latency is 1 cycle.
  - No ack: counter increments each cycle. When counter reaches TIMEOUT_CYCLES-1 without ack: set err_timeout, load_data ← 0, dmem_req drops → DONE.
  - Ack arriving on the same edge as timeout: ack wins and no error is flagged.
- DONE:
  - done = 1 for exactly one cycle.
  - opcode_step_5 ← latched opcode on entry to DONE; held until the next DONE.
  - Unconditional → IDLE.
- Latency, from the edge sampling start to done high:
  - non-memory: 1 cycle;
  - memory: 1 + N cycles, where N = WAIT cycles up to and including the ack.
- dmem_addr, dmem_wdata, dmem_we and dmem_be stay stable while dmem_req is high. They hold their last value otherwise.
- Error flags clear only on reset.

Optional Feature:
- Macro: MEM_STEP_4_SUBWORD_EN.
- Defined:
  - Memory-op set adds lb (100000), lbu (100100), lh (100001), lhu (100101), sb (101000), sh (101001).
  - Alignment is checked per size: byte never misaligned; half requires addr[0] == 0.
  - dmem_be selects the addressed byte or half.
  - dmem_wdata replicates the byte or half across all lanes.
  - load_data is the selected lane, sign-extended for lb/lh and zero-extended for lbu/lhu.
- Undefined: only lw/sw are memory ops. The sub-word opcodes are treated as non-memory ops.

Test Plan:
- lw, alu_result = 0x0000_0010; ack 3 cycles after req with rdata = 0xDEAD_BEEF → one request, dmem_we = 0, done 4 cycles after start, load_data = 0xDEAD_BEEF, opcode_step_5 = 100011.
- sw, addr 0x20, store_data = 0x1234_5678, ack on the first WAIT cycle → dmem_we = 1, dmem_wdata = 0x1234_5678, dmem_be = 1111, done 2 cycles after start, load_data unchanged.
- add (000000) start → no dmem_req, done 1 cycle after start, opcode_step_5 = 000000.
- lw, addr 0x13 → no request, err_misalign = 1, load_data = 0, done 1 cycle later; a subsequent start still completes normally.
- lw, never ack, TIMEOUT_CYCLES = 16 → dmem_req high 16 cycles then low, err_timeout = 1, load_data = 0, done pulse; also rst asserted mid-WAIT drops dmem_req immediately.
- With MEM_STEP_4_SUBWORD_EN: lb, addr 0x3, rdata = 0x80FF_FF7F → dmem_be = 1000, load_data = 0xFFFF_FF80; lhu, addr 0x2, same rdata → dmem_be = 1100, load_data = 0x0000_80FF.
